ifetch_ctrl: RTL

- Fetch-control stage wrapped around the program-counter register.
- Consumes the current PC, issues in-order requests to a valid/ready instruction memory, and buffers returned instructions in a small FIFO for decode.
- Computes the next-PC value fed back into the PC register: hold, +4, or redirect target.
- Decouples the single-cycle datapath from multi-cycle instruction memory latency and absorbs branch/jump redirects by discarding stale responses.

---
 rtl/ifetch_ctrl_pkg.sv | 9 +
 rtl/ifetch_ctrl_if.sv | 28 ++
 rtl/ifetch_ctrl_fifo.sv | 61 ++++++
 rtl/ifetch_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/ifetch_ctrl_pkg.sv
// Shared fetch constants: instruction width, reset vector, PC step and alignment.
package ifetch_ctrl_pkg;

  localparam int unsigned INSTRUCTION_SIZE = 32;
  localparam logic [31:0] RESET_VECTOR     = 32'h0000_0000;
  localparam int unsigned PC_INCR          = 4;
  localparam int unsigned PC_ALIGN_MASK    = 3;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Instruction-memory request/response and decode-side handshakes of the fetch stage.
interface ifetch_ctrl_if
  import ifetch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = INSTRUCTION_SIZE
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rdata, inst_ready
  );

endinterface

// File: rtl/ifetch_ctrl_fifo.sv
// Show-ahead synchronous FIFO with flush; serves as instruction buffer and in-flight PC queue.
module ifetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A push into a full FIFO is only taken when the head leaves in the same cycle
  assign w_do_pop  = i_pop & (r_count != '0);
  assign w_do_push = i_push & ((r_count != CW'(DEPTH)) | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_do_pop) r_rptr <= ptr_inc(r_rptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch control: credit-limited in-order imem requests, next-PC select, redirect flush
// with stale-response dropping, and a show-ahead instruction buffer towards decode.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN      = INSTRUCTION_SIZE,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  ifetch_ctrl_if.master   bus
);

  localparam int unsigned CW = $clog2(MAX_OUTST) + 1;
  localparam int unsigned BW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned SW = CW + BW + 1;
  localparam int unsigned EW = 2 * XLEN;

  logic            r_run;
  logic [CW-1:0]   r_drop;

  logic            w_fire;
  logic            w_rsp;
  logic            w_ib_push;
  logic            w_ib_pop;
  logic            w_ib_full;
  logic            w_ib_empty;
  logic [BW-1:0]   w_ib_count;
  logic [EW-1:0]   w_ib_rdata;
  logic            w_pq_full;
  logic            w_pq_empty;
  logic [CW-1:0]   w_outst;
  logic [XLEN-1:0] w_pq_pc;
  logic [SW-1:0]   w_occ;

  assign w_rsp    = bus.imem_rsp_valid;
  assign w_ib_pop = bus.inst_valid & bus.inst_ready;

  // Slots already promised: the head leaving this cycle frees one, so a
  // zero-wait memory can sustain one fetch per cycle with a 2-entry buffer.
  assign w_occ = SW'(w_outst) + SW'(w_ib_count) - SW'(w_ib_pop);

  assign bus.imem_req_valid = r_run & ~redirect & ~w_pq_full & (w_occ < SW'(BUF_DEPTH));
  assign bus.imem_addr      = pc_cur;
  assign w_fire             = bus.imem_req_valid & bus.imem_req_ready;

  assign w_ib_push = w_rsp & ~redirect & (r_drop == '0);

  always_comb begin
    pc_next = pc_cur;
    if (w_fire)   pc_next = pc_cur + XLEN'(PC_INCR);
    if (redirect) pc_next = redirect_pc & ~XLEN'(PC_ALIGN_MASK);
  end

  // r_run keeps requests off until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run  <= 1'b0;
      r_drop <= '0;
    end else begin
      r_run <= 1'b1;
      if (redirect)                  r_drop <= w_outst - CW'(w_rsp);
      else if (w_rsp && r_drop != '0) r_drop <= r_drop - CW'(1);
    end
  end

  // In-flight request addresses; its occupancy is the outstanding count
  ifetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTST)
  ) u_pc_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fire),
    .i_pop   (w_rsp),
    .i_flush (1'b0),
    .i_wdata (pc_cur),
    .o_rdata (w_pq_pc),
    .o_full  (w_pq_full),
    .o_empty (w_pq_empty),
    .o_count (w_outst)
  );

  ifetch_fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_ib_push),
    .i_pop   (w_ib_pop),
    .i_flush (redirect),
    .i_wdata ({bus.imem_rdata, w_pq_pc}),
    .o_rdata (w_ib_rdata),
    .o_full  (w_ib_full),
    .o_empty (w_ib_empty),
    .o_count (w_ib_count)
  );

  assign bus.inst_valid           = ~w_ib_empty;
  assign {bus.inst, bus.inst_pc}  = w_ib_rdata;

  a_ibuf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_ib_push && w_ib_full && !w_ib_pop));

  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_rsp && w_pq_empty));

endmodule
